multdiv_unit: RTL and testbench

Sequential 32-bit signed multiply/divide unit in the execute stage, alongside the ALU. It is started by the decoded mul/div ALU ops (alu_op 6/7 with R-type opcode) and returns a result plus an overflow flag. That flag is the md_ovf input the exception checker uses to set $rstatus to 4 for mul or 5 for div. The pipeline stalls on busy until data_resultRDY.

---
 rtl/multdiv_unit_if.sv | 25 ++
 rtl/multdiv_unit.sv | 130 +++++++++++++
 tb/tb_multdiv_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/multdiv_unit_if.sv
// Operand/control/result bundle between the execute stage and the mul/div unit.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  // Pipeline side: supplies operands and start pulses, consumes results.
  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  // Unit side.
  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Sequential signed multiply/divide: one radix-2 iteration per cycle, fixed
// WIDTH-cycle latency. Both operations work on operand magnitudes and fix the
// sign at completion; the multiply shift-add and the restoring divide share a
// single 2*WIDTH accumulator ({high half, low half} = {partial, multiplier} or
// {remainder, dividend/quotient}).
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_unit_if.slave md
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mag_reg;      // |A| for multiply, |B| for divide
  logic               sign_reg;     // sign of the final result
  logic               div_zero_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               exception_reg;
  logic               rdy_reg;
  logic               busy_reg;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    // MIN_INT maps to itself, which is its correct unsigned magnitude.
    return v[WIDTH-1] ? -v : v;
  endfunction

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shifted;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] mul_signed;
  logic [WIDTH:0]     ovf_bits;
  logic               mul_ovf;
  logic [WIDTH-1:0]   div_quot;
  logic               last_iter;

  // Next accumulator value for either operation and the signed final results.
  always_comb begin
    add_sum     = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mag_reg};
    mul_step    = acc_reg[0] ? {add_sum, acc_reg[WIDTH-1:1]}
                             : {1'b0, acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1:1]};
    // Remainder stays below the divisor magnitude, so the shifted value fits WIDTH+1 bits.
    div_shifted = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff    = div_shifted - {1'b0, mag_reg};
    if (!div_diff[WIDTH])
      div_step = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    else
      div_step = {div_shifted[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    mul_signed  = sign_reg ? -mul_step : mul_step;
    ovf_bits    = mul_signed[2*WIDTH-1:WIDTH-1];
    mul_ovf     = !((&ovf_bits) || (~|ovf_bits));
    div_quot    = sign_reg ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
    last_iter   = (cnt_reg == CW'(WIDTH - 1));
  end

  // Control FSM with registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      mag_reg       <= '0;
      sign_reg      <= 1'b0;
      div_zero_reg  <= 1'b0;
      result_reg    <= '0;
      exception_reg <= 1'b0;
      rdy_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          rdy_reg <= 1'b0;
          if (md.ctrl_MULT || md.ctrl_DIV) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
            sign_reg <= md.data_operandA[WIDTH-1] ^ md.data_operandB[WIDTH-1];
            div_zero_reg <= (md.data_operandB == '0);
            if (md.ctrl_MULT) begin
              state_reg <= MUL;
              mag_reg   <= magnitude(md.data_operandA);
              acc_reg   <= {{WIDTH{1'b0}}, magnitude(md.data_operandB)};
            end else begin
              state_reg <= DIV;
              mag_reg   <= magnitude(md.data_operandB);
              acc_reg   <= {{WIDTH{1'b0}}, magnitude(md.data_operandA)};
            end
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        MUL: begin
          acc_reg <= mul_step;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_iter) begin
            state_reg     <= DONE;
            result_reg    <= mul_signed[WIDTH-1:0];
            exception_reg <= mul_ovf;
            rdy_reg       <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        DIV: begin
          acc_reg <= div_step;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_iter) begin
            state_reg     <= DONE;
            result_reg    <= div_zero_reg ? '0 : div_quot;
            exception_reg <= div_zero_reg;
            rdy_reg       <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign md.data_result    = result_reg;
  assign md.data_exception = exception_reg;
  assign md.data_resultRDY = rdy_reg;
  assign md.busy           = busy_reg;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: stimulus pushes expected results and
// completion cycles into a scoreboard queue; a negedge monitor pops and checks.
module tb_multdiv_unit;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       name;
    logic [W-1:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t sb_q[$];

  multdiv_unit_if #(.WIDTH(W)) md_if ();

  multdiv_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .md    (md_if)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && md_if.data_resultRDY) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy actual=1 required=0 cycle=%0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn %s result=0x%08h exc=%0b cycle=%0d", e.name,
                 md_if.data_result, md_if.data_exception, cyc);
        check({e.name, "_result"}, md_if.data_result, e.res);
        check({e.name, "_exc"}, W'(md_if.data_exception), W'(e.exc));
        check({e.name, "_latency"}, W'(cyc), W'(e.due));
      end
    end
  end

  // Drive a start pulse at the current negedge; operands are scrambled after
  // the start to show the unit latched them.
  task automatic issue(input string name, input logic mul, input logic div,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic exc, input logic expect_done);
    exp_t e;
    md_if.ctrl_MULT     = mul;
    md_if.ctrl_DIV      = div;
    md_if.data_operandA = a;
    md_if.data_operandB = b;
    if (expect_done) begin
      e.name = name; e.res = res; e.exc = exc; e.due = cyc + 1 + W;
      sb_q.push_back(e);
    end
    @(negedge clock);
    md_if.ctrl_MULT     = 1'b0;
    md_if.ctrl_DIV      = 1'b0;
    md_if.data_operandA = $urandom;
    md_if.data_operandB = $urandom;
  endtask

  // Wait until the scoreboard drains, with a cycle budget.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 4 * W) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=pending required=done", name);
      sb_q.delete();
    end
  endtask

  initial begin
    md_if.ctrl_MULT = 1'b0;
    md_if.ctrl_DIV = 1'b0;
    md_if.data_operandA = '0;
    md_if.data_operandB = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_result", md_if.data_result, '0);
    check("reset_exc", W'(md_if.data_exception), '0);
    check("reset_rdy", W'(md_if.data_resultRDY), '0);
    check("reset_busy", W'(md_if.busy), '0);

    // 1: basic signed multiply, busy during the operation.
    @(negedge clock);
    issue("mul_7x-3", 1, 0, 32'd7, -32'sd3, 32'hFFFF_FFEB, 1'b0, 1);
    check("busy_during_mul", W'(md_if.busy), 32'd1);
    wait_done("mul_7x-3");
    @(negedge clock);
    check("busy_after_mul", W'(md_if.busy), '0);

    // 2: overflow and max-positive multiply.
    issue("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1);
    wait_done("mul_ovf");
    @(negedge clock);
    issue("mul_max", 1, 0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, 1);
    wait_done("mul_max");

    // 3: signed divide truncating toward zero, then divide by zero.
    @(negedge clock);
    issue("div_-100/7", 0, 1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0, 1);
    wait_done("div_-100/7");
    @(negedge clock);
    issue("div_by_zero", 0, 1, 32'd5, 32'd0, 32'h0, 1'b1, 1);
    wait_done("div_by_zero");

    // 4: a divide start while multiplying is ignored.
    @(negedge clock);
    issue("mul_3x4", 1, 0, 32'd3, 32'd4, 32'd12, 1'b0, 1);
    repeat (3) @(negedge clock);
    issue("div_ignored", 0, 1, 32'd100, 32'd10, 32'd0, 1'b0, 0);
    wait_done("mul_3x4");

    // 5: MULT wins over DIV; a new start in the DONE cycle is accepted.
    @(negedge clock);
    issue("mul_both", 1, 1, 32'd6, 32'd3, 32'd18, 1'b0, 1);
    begin
      int n;
      n = 0;
      while (!md_if.data_resultRDY && n < 4 * W) begin
        @(negedge clock);
        n++;
      end
    end
    issue("div_in_done", 0, 1, 32'd6, 32'd3, 32'd2, 1'b0, 1);
    wait_done("div_in_done");

    // 6: reset mid-multiply aborts without a completion pulse.
    @(negedge clock);
    issue("mul_aborted", 1, 0, 32'd9, 32'd9, 32'd0, 1'b0, 0);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_result", md_if.data_result, '0);
    check("abort_exc", W'(md_if.data_exception), '0);
    check("abort_busy", W'(md_if.busy), '0);
    check("abort_rdy", W'(md_if.data_resultRDY), '0);
    repeat (W + 4) @(negedge clock);
    issue("div_minint", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    wait_done("div_minint");

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
